// File: rtl/dqpsk_pkg.sv
// Shared DQPSK types and constants: quadrant/dibit encodings and the Gray map.
// Also used by the transmit differential encoder.
package dqpsk_pkg;

  typedef logic [1:0] quad_t;
  typedef logic [1:0] dibit_t;

  // Quadrant encoding, named by the sign of {I, Q} (P = non-negative, N = negative)
  localparam quad_t QUAD_PP = 2'd0;
  localparam quad_t QUAD_NP = 2'd1;
  localparam quad_t QUAD_NN = 2'd2;
  localparam quad_t QUAD_PN = 2'd3;

  localparam dibit_t GRAY_D0 = 2'b00;
  localparam dibit_t GRAY_D1 = 2'b01;
  localparam dibit_t GRAY_D2 = 2'b11;
  localparam dibit_t GRAY_D3 = 2'b10;

  function automatic dibit_t gray_map(input logic [1:0] d);
    dibit_t g;
    g = GRAY_D0;
    unique case (d)
      2'd0: g = GRAY_D0;
      2'd1: g = GRAY_D1;
      2'd2: g = GRAY_D2;
      2'd3: g = GRAY_D3;
    endcase
    return g;
  endfunction

  function automatic quad_t slice_quad(input logic i_neg, input logic q_neg);
    quad_t q;
    q = QUAD_PP;
    unique case ({q_neg, i_neg})
      2'b00: q = QUAD_PP;
      2'b01: q = QUAD_NP;
      2'b11: q = QUAD_NN;
      2'b10: q = QUAD_PN;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Synchronous FIFO with push/pop/full/empty; a push while full succeeds only
// when a pop happens in the same cycle (pop then push).
module sym_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/dqpsk_symbol_demod.sv
// DQPSK symbol demodulator: decimate, hard-slice, differentially decode, buffer.
// DQPSK_DIFF_DECODE_EN selects differential decode; undefined gives coherent QPSK.
module dqpsk_symbol_demod
  import dqpsk_pkg::*;
#(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned SPS        = 100,
  parameter int unsigned PHASE      = 50,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic [2*DATA_W-1:0] s_axis_data_tdata,
  input  logic              s_axis_data_tvalid,
  input  logic              sym_align,
  output logic [1:0]        m_axis_data_tdata,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  output logic              overflow
);

  localparam int unsigned CNT_W = (SPS > 1) ? $clog2(SPS) : 1;

  logic [CNT_W-1:0] phase_q, phase_d, beat_idx;
  logic             decide;
  quad_t            quad_now, q_q;
  logic             stb_q;
  dibit_t           dibit;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic             overflow_q;
  logic             unused_bits;

  // Only the sign bits feed the slicer
  assign unused_bits = ^{s_axis_data_tdata[2*DATA_W-2:DATA_W], s_axis_data_tdata[DATA_W-2:0]};

  // An aligned beat counts as index 0, so the counter resumes from 1
  always_comb begin
    beat_idx = sym_align ? '0 : phase_q;
    phase_d  = phase_q;
    if (s_axis_data_tvalid) begin
      phase_d = (beat_idx == CNT_W'(SPS - 1)) ? '0 : beat_idx + CNT_W'(1);
    end else if (sym_align) begin
      phase_d = '0;
    end
  end

  assign decide   = s_axis_data_tvalid && (beat_idx == CNT_W'(PHASE));
  assign quad_now = slice_quad(s_axis_data_tdata[DATA_W-1], s_axis_data_tdata[2*DATA_W-1]);

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      q_q     <= QUAD_PP;
      stb_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      stb_q   <= decide;
      if (decide) q_q <= quad_now;
    end
  end

`ifdef DQPSK_DIFF_DECODE_EN
  quad_t q_prev_q;
  logic [1:0] delta;

  assign delta = q_q - q_prev_q;
  assign dibit = gray_map(delta);

  // Reference advances even when the dibit itself is dropped
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      q_prev_q <= QUAD_PP;
    end else if (stb_q) begin
      q_prev_q <= q_q;
    end
  end
`else
  assign dibit = gray_map(q_q);
`endif

  assign fifo_pop           = m_axis_data_tvalid && m_axis_data_tready;
  assign m_axis_data_tvalid = !fifo_empty;
  assign overflow           = overflow_q;

  sym_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_sym_fifo (
    .clk   (aclk),
    .rst   (rst),
    .push  (stb_q),
    .wdata (dibit),
    .pop   (fifo_pop),
    .rdata (m_axis_data_tdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (stb_q && fifo_full && !m_axis_data_tready) begin
      overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dqpsk_symbol_demod.sv
// Directed bench for dqpsk_symbol_demod with SPS=4, PHASE=2, FIFO_DEPTH=4.
// Expected dibits follow the build mode selected by DQPSK_DIFF_DECODE_EN.
module tb_dqpsk_symbol_demod;

  localparam int unsigned DATA_W     = 24;
  localparam int unsigned SPS        = 4;
  localparam int unsigned PHASE      = 2;
  localparam int unsigned FIFO_DEPTH = 4;

  logic                aclk = 1'b0;
  logic                rst;
  logic [2*DATA_W-1:0] s_axis_data_tdata;
  logic                s_axis_data_tvalid;
  logic                sym_align;
  logic [1:0]          m_axis_data_tdata;
  logic                m_axis_data_tvalid;
  logic                m_axis_data_tready;
  logic                overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] got_q[$];
  logic [1:0] exp_q[$];
`ifdef DQPSK_DIFF_DECODE_EN
  logic [1:0] prev_m;
`endif

  dqpsk_symbol_demod #(
    .DATA_W     (DATA_W),
    .SPS        (SPS),
    .PHASE      (PHASE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .aclk               (aclk),
    .rst                (rst),
    .s_axis_data_tdata  (s_axis_data_tdata),
    .s_axis_data_tvalid (s_axis_data_tvalid),
    .sym_align          (sym_align),
    .m_axis_data_tdata  (m_axis_data_tdata),
    .m_axis_data_tvalid (m_axis_data_tvalid),
    .m_axis_data_tready (m_axis_data_tready),
    .overflow           (overflow)
  );

  always #5 aclk = ~aclk;

  // Handshakes are sampled mid-cycle; inputs only change just after posedge
  always @(negedge aclk) begin
    if (!rst && m_axis_data_tvalid && m_axis_data_tready) got_q.push_back(m_axis_data_tdata);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] gray_ref(input logic [1:0] d);
    case (d)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      2'd2:    return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic expect_sym(input logic [1:0] q, input logic keep);
`ifdef DQPSK_DIFF_DECODE_EN
    if (keep) exp_q.push_back(gray_ref(q - prev_m));
    prev_m = q;
`else
    if (keep) exp_q.push_back(gray_ref(q));
`endif
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic beat(input logic [DATA_W-1:0] iv, input logic [DATA_W-1:0] qv,
                      input logic al);
    s_axis_data_tdata  = {qv, iv};
    s_axis_data_tvalid = 1'b1;
    sym_align          = al;
    tick();
    s_axis_data_tvalid = 1'b0;
    sym_align          = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] amp_i(input logic [1:0] q);
    return (q == 2'd1 || q == 2'd2) ? -DATA_W'(1000) : DATA_W'(1000);
  endfunction

  function automatic logic [DATA_W-1:0] amp_q(input logic [1:0] q);
    return (q >= 2'd2) ? -DATA_W'(1000) : DATA_W'(1000);
  endfunction

  task automatic send_raw(input logic [DATA_W-1:0] iv, input logic [DATA_W-1:0] qv,
                          input logic [1:0] q, input logic keep);
    for (int b = 0; b < int'(SPS); b++) beat(iv, qv, 1'b0);
    expect_sym(q, keep);
  endtask

  task automatic send_sym(input logic [1:0] q, input logic keep);
    send_raw(amp_i(q), amp_q(q), q, keep);
  endtask

  task automatic drain_check(input string tag);
    int n;
    n = 0;
    m_axis_data_tready = 1'b1;
    while (got_q.size() < exp_q.size() && n < 64) begin
      tick();
      n++;
    end
    repeat (2) tick();
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_dibit%0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst                = 1'b1;
    s_axis_data_tdata  = '0;
    s_axis_data_tvalid = 1'b0;
    sym_align          = 1'b0;
    m_axis_data_tready = 1'b0;
`ifdef DQPSK_DIFF_DECODE_EN
    prev_m = 2'd0;
`endif
    #1;
    chk("reset_tvalid", m_axis_data_tvalid, 1'b0);
    chk("reset_tdata", m_axis_data_tdata, 2'b00);
    chk("reset_overflow", overflow, 1'b0);
    tick();
    tick();
    rst                = 1'b0;
    m_axis_data_tready = 1'b1;

    // Constant +1000/+1000: first dibit appears two clocks after beat index 2
    beat(DATA_W'(1000), DATA_W'(1000), 1'b0);
    beat(DATA_W'(1000), DATA_W'(1000), 1'b0);
    beat(DATA_W'(1000), DATA_W'(1000), 1'b0);
    @(negedge aclk);
    chk("latency_early", m_axis_data_tvalid, 1'b0);
    beat(DATA_W'(1000), DATA_W'(1000), 1'b0);
    expect_sym(2'd0, 1'b1);
    @(negedge aclk);
    chk("latency_valid", m_axis_data_tvalid, 1'b1);
    chk("latency_dibit", m_axis_data_tdata, 2'b00);
    for (int s = 0; s < 3; s++) send_sym(2'd0, 1'b1);
    drain_check("const");

    // Quadrant sequence
    send_sym(2'd0, 1'b1);
    send_sym(2'd1, 1'b1);
    send_sym(2'd3, 1'b1);
    send_sym(2'd3, 1'b1);
    send_sym(2'd2, 1'b1);
    drain_check("seq");

    // Zero slices as positive; Q=-1 is negative
    send_raw(DATA_W'(0), DATA_W'(0), 2'd0, 1'b1);
    send_raw(DATA_W'(0), -DATA_W'(1), 2'd3, 1'b1);
    drain_check("zero");

    // Stall: four held, fifth and sixth dropped
    m_axis_data_tready = 1'b0;
    send_sym(2'd1, 1'b1);
    send_sym(2'd2, 1'b1);
    send_sym(2'd3, 1'b1);
    send_sym(2'd0, 1'b1);
    chk("stall4_overflow", overflow, 1'b0);
    chk("stall4_tvalid", m_axis_data_tvalid, 1'b1);
    send_sym(2'd1, 1'b0);
    chk("stall5_overflow", overflow, 1'b1);
    send_sym(2'd2, 1'b0);
    chk("stall6_overflow", overflow, 1'b1);
    drain_check("stall");
    send_sym(2'd0, 1'b1);
    drain_check("after_drop");

    // sym_align mid-symbol: decision exactly PHASE beats after realignment
    m_axis_data_tready = 1'b0;
    beat(amp_i(2'd3), amp_q(2'd3), 1'b0);
    tick();
    sym_align = 1'b1;
    tick();
    sym_align = 1'b0;
    beat(amp_i(2'd3), amp_q(2'd3), 1'b0);
    beat(amp_i(2'd3), amp_q(2'd3), 1'b0);
    beat(amp_i(2'd3), amp_q(2'd3), 1'b0);
    @(negedge aclk);
    chk("align_early", m_axis_data_tvalid, 1'b0);
    beat(amp_i(2'd3), amp_q(2'd3), 1'b0);
    expect_sym(2'd3, 1'b1);
    @(negedge aclk);
    chk("align_valid", m_axis_data_tvalid, 1'b1);
    drain_check("align");

    // Reset mid-FIFO clears outputs without waiting for a clock edge
    m_axis_data_tready = 1'b0;
    send_sym(2'd1, 1'b1);
    send_sym(2'd2, 1'b1);
    chk("prerst_tvalid", m_axis_data_tvalid, 1'b1);
    chk("prerst_overflow", overflow, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_tvalid", m_axis_data_tvalid, 1'b0);
    chk("rst_async_overflow", overflow, 1'b0);
    got_q.delete();
    exp_q.delete();
`ifdef DQPSK_DIFF_DECODE_EN
    prev_m = 2'd0;
`endif
    tick();
    tick();
    rst = 1'b0;

    // Full FIFO with a read on the write edge: no overflow, nothing lost
    send_sym(2'd0, 1'b1);
    send_sym(2'd1, 1'b1);
    send_sym(2'd2, 1'b1);
    send_sym(2'd3, 1'b1);
    chk("full_overflow", overflow, 1'b0);
    beat(amp_i(2'd0), amp_q(2'd0), 1'b0);
    beat(amp_i(2'd0), amp_q(2'd0), 1'b0);
    beat(amp_i(2'd0), amp_q(2'd0), 1'b0);
    m_axis_data_tready = 1'b1;
    beat(amp_i(2'd0), amp_q(2'd0), 1'b0);
    m_axis_data_tready = 1'b0;
    expect_sym(2'd0, 1'b1);
    @(negedge aclk);
    chk("full_rw_overflow", overflow, 1'b0);
    chk("full_rw_tvalid", m_axis_data_tvalid, 1'b1);
    chk("full_rw_popped", got_q.size(), 1);
    drain_check("full_rw");
    chk("final_overflow", overflow, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
